// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - round-robin arbiter sharing one 4-bit Gray/binary converter between two requesters
// Optional result checker: define GRAY_ARB_CHECK_EN
module gray_conv_arbiter #(
    parameter int TIMEOUT_CYC = 4,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [3:0] din0,
    input  logic       mode0,
    output logic       ack0,
    input  logic       req1,
    input  logic [3:0] din1,
    input  logic       mode1,
    output logic       ack1,
    output logic [3:0] conv_din,
    output logic       conv_en,
    output logic       conv_gray_n,
    input  logic [3:0] conv_dout,
    input  logic       conv_valid,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q;
    logic             ptr_q;
    logic             granted_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ack0_q;
    logic             ack1_q;
    logic [3:0]       conv_din_q;
    logic             conv_en_q;
    logic             conv_gray_n_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [3:0]       rsp_data_q;
    logic             rsp_err_q;
    logic             grant_id_d;
    logic             chk_err;

    // Winner selection: a lone request wins outright; the first tie after reset
    // goes to requester 0, later ties go to whoever was not granted last.
    always_comb begin
        grant_id_d = 1'b0;
        if (req0 && req1) begin
            grant_id_d = granted_q ? ~ptr_q : 1'b0;
        end else begin
            grant_id_d = req1;
        end
    end

    assign cnt_d = cnt_q + 1'b1;

`ifdef GRAY_ARB_CHECK_EN
    logic [3:0] exp_dout;

    // Reference conversion of the registered operand; Gray->binary bit i is the XOR of all bits at or above i.
    always_comb begin
        exp_dout = 4'b0000;
        if (conv_gray_n_q) begin
            for (int i = 0; i < 4; i++) begin
                exp_dout[i] = ^(conv_din_q >> i);
            end
        end else begin
            exp_dout = conv_din_q ^ (conv_din_q >> 1);
        end
    end

    assign chk_err = (conv_dout != exp_dout);
`else
    assign chk_err = 1'b0;
`endif

    // Sequencer: grant in IDLE, wait bounded time for the converter in DRIVE, hold the response in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= 1'b0;
            granted_q     <= 1'b0;
            cnt_q         <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            conv_din_q    <= 4'b0000;
            conv_en_q     <= 1'b0;
            conv_gray_n_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= 4'b0000;
            rsp_err_q     <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        conv_din_q    <= grant_id_d ? din1 : din0;
                        conv_gray_n_q <= grant_id_d ? mode1 : mode0;
                        conv_en_q     <= 1'b1;
                        rsp_id_q      <= grant_id_d;
                        ack0_q        <= ~grant_id_d;
                        ack1_q        <= grant_id_d;
                        cnt_q         <= '0;
                        ptr_q         <= grant_id_d;
                        granted_q     <= 1'b1;
                        state_q       <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (conv_valid) begin
                        rsp_data_q  <= conv_dout;
                        rsp_err_q   <= chk_err;
                        rsp_valid_q <= 1'b1;
                        conv_en_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_data_q  <= 4'b0000;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        conv_en_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign conv_din    = conv_din_q;
    assign conv_en     = conv_en_q;
    assign conv_gray_n = conv_gray_n_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - randomized self-checking bench for gray_conv_arbiter
module tb_gray_conv_arbiter;

    localparam int TIMEOUT_CYC = 4;
`ifdef GRAY_ARB_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] din0 = 4'h0, din1 = 4'h0;
    logic       mode0 = 1'b0, mode1 = 1'b0;
    logic [3:0] conv_dout = 4'h0;
    logic       conv_valid = 1'b0;
    logic       rsp_ready = 1'b0;
    logic       ack0, ack1, conv_en, conv_gray_n, rsp_valid, rsp_id, rsp_err, busy;
    logic [3:0] conv_din, rsp_data;

    gray_conv_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .din0(din0), .mode0(mode0), .ack0(ack0),
        .req1(req1), .din1(din1), .mode1(mode1), .ack1(ack1),
        .conv_din(conv_din), .conv_en(conv_en), .conv_gray_n(conv_gray_n),
        .conv_dout(conv_dout), .conv_valid(conv_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Expected outputs after the most recent edge
    logic       e_ack0, e_ack1, e_conv_en, e_conv_gray_n, e_rsp_valid, e_rsp_id, e_rsp_err;
    logic [3:0] e_conv_din, e_rsp_data;
    // Transaction-level model state
    logic       m_active;      // a request has been granted and its response not yet taken
    logic       m_in_drive;    // waiting on the converter
    int         m_k;           // converter cycles elapsed in the current transaction
    logic       m_granted_any;
    logic       m_last;
    logic       model_ok = 1'b0;
    // Converter behaviour for the current transaction
    int         lat = 0;
    logic [3:0] bad_mask = 4'h0;
    logic       random_mode = 1'b0;

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [3:0] ref_conv(input logic [3:0] d, input logic m);
        return m ? g2b(d) : b2g(d);
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs that were present at that edge
    task automatic model_advance();
        logic w;
        if (rst) begin
            e_ack0 = 0; e_ack1 = 0; e_conv_din = 0; e_conv_en = 0; e_conv_gray_n = 0;
            e_rsp_valid = 0; e_rsp_id = 0; e_rsp_data = 0; e_rsp_err = 0;
            m_active = 0; m_in_drive = 0; m_k = 0; m_granted_any = 0; m_last = 0;
            return;
        end
        e_ack0 = 0;
        e_ack1 = 0;
        if (!m_active) begin
            if (req0 || req1) begin
                if (req0 && req1) w = m_granted_any ? !m_last : 1'b0;
                else w = req1;
                m_last = w; m_granted_any = 1; m_active = 1; m_in_drive = 1; m_k = 0;
                e_conv_din = w ? din1 : din0;
                e_conv_gray_n = w ? mode1 : mode0;
                e_conv_en = 1; e_rsp_id = w;
                e_ack0 = !w; e_ack1 = w;
            end
        end else if (m_in_drive) begin
            if (conv_valid) begin
                e_rsp_data = conv_dout;
                e_rsp_err = CHECK_EN && (conv_dout != ref_conv(e_conv_din, e_conv_gray_n));
                e_rsp_valid = 1; e_conv_en = 0; m_in_drive = 0;
            end else if (m_k + 1 == TIMEOUT_CYC) begin
                e_rsp_data = 0; e_rsp_err = 1; e_rsp_valid = 1; e_conv_en = 0; m_in_drive = 0;
            end else begin
                m_k++;
            end
        end else if (rsp_ready) begin
            e_rsp_valid = 0; e_rsp_err = 0; m_active = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_advance();
        model_ok = 1'b1;
        if (random_mode && (e_ack0 || e_ack1)) begin
            lat = $urandom_range(0, 5);
            bad_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        end
        if (m_active && m_in_drive) begin
            conv_valid = (m_k == lat);
            conv_dout = ref_conv(e_conv_din, e_conv_gray_n) ^ bad_mask;
        end else begin
            conv_valid = 1'($urandom_range(0, 1));
            conv_dout = 4'($urandom_range(0, 15));
        end
    endtask

    // Compare process: every cycle, mid-period, DUT against model
    initial begin : compare_proc
        wait (model_ok);
        forever begin
            @(negedge clk);
            chk("ack0", {3'b0, ack0}, {3'b0, e_ack0});
            chk("ack1", {3'b0, ack1}, {3'b0, e_ack1});
            chk("conv_din", conv_din, e_conv_din);
            chk("conv_en", {3'b0, conv_en}, {3'b0, e_conv_en});
            chk("conv_gray_n", {3'b0, conv_gray_n}, {3'b0, e_conv_gray_n});
            chk("rsp_valid", {3'b0, rsp_valid}, {3'b0, e_rsp_valid});
            chk("rsp_id", {3'b0, rsp_id}, {3'b0, e_rsp_id});
            chk("rsp_data", rsp_data, e_rsp_data);
            chk("rsp_err", {3'b0, rsp_err}, {3'b0, e_rsp_err});
            chk("busy", {3'b0, busy}, {3'b0, m_active});
        end
    end

    initial begin : main_proc
        // Reset
        cycle(); cycle();
        rst = 0;
        chk("rst_busy", {3'b0, busy}, 4'h0);
        chk("rst_rsp_valid", {3'b0, rsp_valid}, 4'h0);
        chk("rst_conv_din", conv_din, 4'h0);

        // Binary to Gray, immediate converter answer
        lat = 0; bad_mask = 0; rsp_ready = 1;
        req0 = 1; din0 = 4'b1011; mode0 = 0;
        cycle();
        chk("d1_ack0", {3'b0, ack0}, 4'h1);
        chk("d1_conv_din", conv_din, 4'b1011);
        req0 = 0;
        cycle();
        chk("d1_rsp_valid", {3'b0, rsp_valid}, 4'h1);
        chk("d1_rsp_data", rsp_data, 4'b1110);
        chk("d1_rsp_id", {3'b0, rsp_id}, 4'h0);
        chk("d1_rsp_err", {3'b0, rsp_err}, 4'h0);
        cycle();

        // Gray to binary on requester 1
        req1 = 1; din1 = 4'b1101; mode1 = 1;
        cycle();
        chk("d2_ack1", {3'b0, ack1}, 4'h1);
        req1 = 0;
        cycle();
        chk("d2_rsp_data", rsp_data, 4'b1001);
        chk("d2_rsp_id", {3'b0, rsp_id}, 4'h1);
        chk("d2_rsp_err", {3'b0, rsp_err}, 4'h0);
        cycle();

        // Ties after reset: 0, then 1, then 0
        rst = 1; cycle(); rst = 0;
        req0 = 1; din0 = 4'b0001; mode0 = 0;
        req1 = 1; din1 = 4'b0010; mode1 = 0;
        cycle();
        chk("d3_tie1_ack0", {3'b0, ack0}, 4'h1);
        chk("d3_tie1_ack1", {3'b0, ack1}, 4'h0);
        cycle(); cycle(); cycle();
        chk("d3_tie2_ack1", {3'b0, ack1}, 4'h1);
        cycle(); cycle(); cycle();
        chk("d3_tie3_ack0", {3'b0, ack0}, 4'h1);
        req0 = 0; req1 = 0;
        cycle(); cycle(); cycle();

        // Timeout: exactly TIMEOUT_CYC drive cycles
        lat = 99; rsp_ready = 0;
        req0 = 1; din0 = 4'b0101; mode0 = 1;
        cycle();
        req0 = 0;
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            chk("d4_conv_en_drive", {3'b0, conv_en}, 4'h1);
            chk("d4_no_rsp_yet", {3'b0, rsp_valid}, 4'h0);
            cycle();
        end
        chk("d4_rsp_valid", {3'b0, rsp_valid}, 4'h1);
        chk("d4_rsp_err", {3'b0, rsp_err}, 4'h1);
        chk("d4_rsp_data", rsp_data, 4'h0);
        chk("d4_conv_en_off", {3'b0, conv_en}, 4'h0);

        // Back-pressure with requester 1 waiting
        req1 = 1; din1 = 4'b0111; mode1 = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("d5_hold_ack1", {3'b0, ack1}, 4'h0);
            chk("d5_hold_valid", {3'b0, rsp_valid}, 4'h1);
            chk("d5_hold_err", {3'b0, rsp_err}, 4'h1);
        end
        rsp_ready = 1;
        cycle();
        chk("d5_released", {3'b0, rsp_valid}, 4'h0);
        cycle();
        chk("d5_ack1", {3'b0, ack1}, 4'h1);
        req1 = 0;
        rst = 1;
        cycle();
        rst = 0;
        chk("d5_rst_conv_en", {3'b0, conv_en}, 4'h0);
        chk("d5_rst_busy", {3'b0, busy}, 4'h0);
        chk("d5_rst_conv_din", conv_din, 4'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("d5_no_rsp", {3'b0, rsp_valid}, 4'h0);
        end

        // Wrong converter answer
        lat = 0; bad_mask = 4'b0001;
        req0 = 1; din0 = 4'b0110; mode0 = 0;
        cycle();
        req0 = 0;
        cycle();
        chk("d6_rsp_data", rsp_data, 4'b0100);
        chk("d6_rsp_err", {3'b0, rsp_err}, {3'b0, CHECK_EN});
        cycle();
        bad_mask = 0;

        // Randomized traffic
        random_mode = 1;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            rsp_ready = 1'($urandom_range(0, 1));
            if (!req0) begin
                if ($urandom_range(0, 2) == 0) begin
                    req0 = 1; din0 = 4'($urandom_range(0, 15)); mode0 = 1'($urandom_range(0, 1));
                end
            end else if (e_ack0) begin
                if ($urandom_range(0, 1) == 0) req0 = 0;
                else begin din0 = 4'($urandom_range(0, 15)); mode0 = 1'($urandom_range(0, 1)); end
            end
            if (!req1) begin
                if ($urandom_range(0, 2) == 0) begin
                    req1 = 1; din1 = 4'($urandom_range(0, 15)); mode1 = 1'($urandom_range(0, 1));
                end
            end else if (e_ack1) begin
                if ($urandom_range(0, 1) == 0) req1 = 0;
                else begin din1 = 4'($urandom_range(0, 15)); mode1 = 1'($urandom_range(0, 1)); end
            end
            cycle();
        end

        rst = 0; req0 = 0; req1 = 0; rsp_ready = 1;
        for (int i = 0; i < 20; i++) cycle();
        chk("end_idle", {3'b0, busy}, 4'h0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
